// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA1 padding stage: FSM encoding, pad constants
// and the rule that picks the pad state that follows the last message word.
package sha1_pkg;

  typedef enum logic [2:0] {
    S_DATA,
    S_MARK,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO
  } state_t;

  localparam logic [31:0] PAD_MARK        = 32'h8000_0000;
  localparam int          WORDS_PER_BLOCK = 16;
  localparam int          BYTES_PER_WORD  = 4;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;
  localparam logic [3:0]  LEN_HI_IDX      = 4'd14;
  localparam logic [3:0]  LEN_LO_IDX      = 4'd15;

  // A marker-carrying word at idx 13 leaves the length slots free immediately.
  function automatic state_t pad_entry_state(input logic [3:0] idx);
    return (idx == LEN_HI_IDX - 4'd1) ? S_LEN_HI : S_ZERO;
  endfunction

  // Marker at idx 14 leaves no room for the length: finish this block, then one more.
  function automatic logic pad_needs_extra(input logic [3:0] idx);
    return idx == LEN_HI_IDX;
  endfunction

endpackage

// File: rtl/sha1_padder_if.sv
// Word-stream handshake between the message source, the padder and the SHA1 loader.
interface sha1_padder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_msg_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_msg_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_msg_last
  );

endinterface

// File: rtl/sha1_byte_pad.sv
// Combinational marker insertion for the final message word: keeps the valid
// bytes, puts 0x80 right after them and clears the rest.
module sha1_byte_pad
  import sha1_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] data_o,
  output logic [2:0]  nbytes_o,
  output logic        full_o,
  output logic        err_o
);

  // Counts above a full word are illegal and are handled as a full word.
  assign err_o    = nbytes_i > 3'(BYTES_PER_WORD);
  assign nbytes_o = err_o ? 3'(BYTES_PER_WORD) : nbytes_i;
  assign full_o   = nbytes_o == 3'(BYTES_PER_WORD);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign data_o[31-8*gi -: 8] = (3'(gi) < nbytes_o)  ? data_i[31-8*gi -: 8] :
                                    (3'(gi) == nbytes_o) ? PAD_BYTE : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/sha1_padder.sv
// SHA1 message padder: turns a byte-aligned word stream into 512-bit blocks
// (16 indexed words) with the 0x80 marker, zero fill and 64-bit bit length.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 64
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  sha1_padder_if.slave bus,
  output logic         busy,
  output logic         err
);

  state_t                state_q;
  logic                  extra_q;
  logic [3:0]            idx_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  len_d;
  logic [LEN_WIDTH-1:0]  len_add;
  logic                  len_carry;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [3:0]            out_idx_q;
  logic                  out_msg_last_q;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  adv, accept, load;
  logic [31:0]           pad_word;
  logic [2:0]            pad_nbytes;
  logic                  pad_full, pad_err;

  sha1_byte_pad u_byte_pad (
    .data_i   (bus.in_data),
    .nbytes_i (bus.in_nbytes),
    .data_o   (pad_word),
    .nbytes_o (pad_nbytes),
    .full_o   (pad_full),
    .err_o    (pad_err)
  );

  assign adv    = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  // Pad states produce a word on every free output slot; data state waits for input.
  assign load   = (state_q == S_DATA) ? accept : adv;

  assign len_add              = bus.in_last ? LEN_WIDTH'({pad_nbytes, 3'b000}) : LEN_WIDTH'(DATA_WIDTH);
  assign {len_carry, len_d}   = {1'b0, len_q} + {1'b0, len_add};
  assign err_d  = err_q | (accept & (len_carry | (bus.in_last & pad_err)));
  assign busy_d = accept | (busy_q & ~(out_valid_q & bus.out_ready & out_msg_last_q));

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state_q        <= S_DATA;
      extra_q        <= 1'b0;
      idx_q          <= 4'd0;
      len_q          <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_idx_q      <= 4'd0;
      out_msg_last_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      if (load) begin
        out_valid_q    <= 1'b1;
        out_idx_q      <= idx_q;
        idx_q          <= idx_q + 4'd1;
        out_msg_last_q <= 1'b0;
        unique case (state_q)
          S_DATA: begin
            len_q      <= len_d;
            out_data_q <= bus.in_last ? pad_word : bus.in_data;
            if (bus.in_last) begin
              if (pad_full) begin
                state_q <= S_MARK;
              end else begin
                state_q <= pad_entry_state(idx_q);
                extra_q <= pad_needs_extra(idx_q);
              end
            end
          end
          S_MARK: begin
            out_data_q <= PAD_MARK;
            state_q    <= pad_entry_state(idx_q);
            extra_q    <= pad_needs_extra(idx_q);
          end
          S_ZERO: begin
            out_data_q <= '0;
            if (idx_q == LEN_LO_IDX) begin
              extra_q <= 1'b0;
            end else if (idx_q == LEN_HI_IDX - 4'd1 && !extra_q) begin
              state_q <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            out_data_q <= len_q[LEN_WIDTH-1 -: DATA_WIDTH];
            state_q    <= S_LEN_LO;
          end
          S_LEN_LO: begin
            out_data_q     <= len_q[DATA_WIDTH-1:0];
            out_msg_last_q <= 1'b1;
            len_q          <= '0;
            state_q        <= S_DATA;
          end
          default: state_q <= S_DATA;
        endcase
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = (state_q == S_DATA) && adv;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_msg_last = out_msg_last_q;
  assign busy             = busy_q;
  assign err              = err_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: a byte-level padding model fills the
// expected queue, the driver captures produced words, each test compares them.
module tb_sha1_padder;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  logic busy, err;

  sha1_padder_if bus ();

  sha1_padder dut (
    .wb_clk_i (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  word_t       exp_q[$];
  word_t       act_q[$];
  logic [31:0] msg_q[$];
  int          msg_nb;
  bit          timeout;
  bit          busy_seen;
  int          stall_viol;

  task automatic load_bytes(input int len_bytes);
    int nw;
    nw = (len_bytes == 0) ? 1 : (len_bytes + 3) / 4;
    msg_q.delete();
    for (int i = 0; i < nw; i++) msg_q.push_back($urandom);
    msg_nb = len_bytes - 4 * (nw - 1);
  endtask

  // Reference padding built byte by byte, independent of any block/idx bookkeeping.
  task automatic push_expected();
    byte unsigned    b[$];
    int              nb, nw;
    longint unsigned bits;
    logic [31:0]     w;
    nb = (msg_nb > 4) ? 4 : msg_nb;
    for (int i = 0; i < msg_q.size(); i++) begin
      w = msg_q[i];
      for (int j = 0; j < ((i == msg_q.size() - 1) ? nb : 4); j++) b.push_back(w[31-8*j -: 8]);
    end
    bits = 64'(b.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int k = 7; k >= 0; k--) b.push_back(8'(bits >> (8 * k)));
    nw = b.size() / 4;
    for (int i = 0; i < nw; i++)
      exp_q.push_back('{data: {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]}, idx: 4'(i % 16), last: (i == nw - 1)});
  endtask

  task automatic run_message(input int stall_pct);
    int    sent, cycles;
    bit    done, stalled;
    word_t held, cur;
    sent = 0; cycles = 0; done = 0; stalled = 0; held = '0;
    timeout = 0; stall_viol = 0; busy_seen = 0;
    while (!done) begin
      @(negedge clk);
      if (sent < msg_q.size()) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = msg_q[sent];
        bus.in_last   = (sent == msg_q.size() - 1);
        bus.in_nbytes = bus.in_last ? 3'(msg_nb) : 3'($urandom_range(0, 7));
      end else begin
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_nbytes = 3'd0; bus.in_data = '0;
      end
      bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      cur = '{data: bus.out_data, idx: bus.out_idx, last: bus.out_msg_last};
      if (busy) busy_seen = 1;
      if (stalled && (!bus.out_valid || cur !== held)) stall_viol++;
      stalled = bus.out_valid && !bus.out_ready;
      if (stalled) begin
        held = cur;
        if (bus.in_ready) stall_viol++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        act_q.push_back(cur);
        $display("  word idx=%0d data=%h msg_last=%0d", cur.idx, cur.data, cur.last);
        if (cur.last) done = 1;
      end
      cycles++;
      if (cycles > 2000) begin timeout = 1; done = 1; end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_assert++;
    if ({bus.out_data, bus.out_idx, bus.out_msg_last} !== 37'd0) begin
      n_fail++; $display("FAIL reset_out_regs: got data %h idx %0d last %b want all zero", bus.out_data, bus.out_idx, bus.out_msg_last);
    end
    n_assert++;
    if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got busy %b err %b want 0 0", busy, err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_abc();
    word_t e, a;
    msg_q.delete(); msg_q.push_back(32'h6162_6300); msg_nb = 3;
    push_expected();
    run_message(0);
    n_assert++;
    if (act_q.size() != 16 || act_q[0].data !== 32'h6162_6380 || act_q[15].data !== 32'h0000_0018 || act_q[15].last !== 1'b1) begin
      n_fail++; $display("FAIL abc_known: got %0d words, first %h, want 16 words first 61626380 last 00000018", act_q.size(), (act_q.size() > 0) ? act_q[0].data : 32'hx);
    end
    n_assert++;
    if (timeout || act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL abc_count: got %0d words (timeout %0d) want %0d", act_q.size(), timeout, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
      if (a !== e) begin n_fail++; $display("FAIL abc_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
    end
    exp_q.delete(); act_q.delete();
    n_assert++;
    if (!busy_seen || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL abc_flags: got busy_seen %0d busy %b err %b want 1 0 0", busy_seen, busy, err);
    end
  endtask

  task automatic test_empty();
    word_t e, a;
    load_bytes(0);
    push_expected();
    run_message(0);
    n_assert++;
    if (timeout || act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL empty_count: got %0d words (timeout %0d) want %0d", act_q.size(), timeout, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
      if (a !== e) begin n_fail++; $display("FAIL empty_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_55();
    word_t e, a;
    load_bytes(55);
    push_expected();
    run_message(0);
    n_assert++;
    if (timeout || act_q.size() != 16 || exp_q.size() != 16) begin
      n_fail++; $display("FAIL len55_count: got %0d words (timeout %0d) want 16", act_q.size(), timeout);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
      if (a !== e) begin n_fail++; $display("FAIL len55_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_56();
    word_t e, a;
    load_bytes(56);
    push_expected();
    run_message(0);
    n_assert++;
    if (timeout || act_q.size() != 32 || exp_q.size() != 32) begin
      n_fail++; $display("FAIL len56_count: got %0d words (timeout %0d) want 32", act_q.size(), timeout);
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
      if (a !== e) begin n_fail++; $display("FAIL len56_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
    end
    exp_q.delete(); act_q.delete();
    n_assert++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL len56_err: got err %b want 0", err); end
  endtask

  task automatic test_stall();
    word_t e, a;
    for (int r = 0; r < 2; r++) begin
      load_bytes((r == 0) ? 55 : 56);
      push_expected();
      run_message(40);
      n_assert++;
      if (timeout || act_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL stall_count: got %0d words (timeout %0d) want %0d", act_q.size(), timeout, exp_q.size());
      end
      n_assert++;
      if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d stall violations want 0", stall_viol); end
      while (exp_q.size() > 0 && act_q.size() > 0) begin
        e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
        if (a !== e) begin n_fail++; $display("FAIL stall_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
      end
      exp_q.delete(); act_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    word_t e, a;
    int    sent;
    bit    found;
    load_bytes(55);
    sent = 0; found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      bus.in_valid  = (sent < msg_q.size());
      bus.in_data   = (sent < msg_q.size()) ? msg_q[sent] : 32'h0;
      bus.in_last   = (sent == msg_q.size() - 1);
      bus.in_nbytes = 3'(msg_nb);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid && bus.out_idx == 4'd7) found = 1;
      else if (bus.in_valid && bus.in_ready) sent++;
    end
    reset = 1'b1;
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL midreset_reach: got no idx 7 word want one within 200 cycles"); end
    @(posedge clk);
    #1;
    n_assert++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got out_valid %b busy %b want 0 0", bus.out_valid, busy);
    end
    @(negedge clk);
    reset = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    msg_q.delete(); msg_q.push_back(32'h6162_6300); msg_nb = 3;
    push_expected();
    run_message(0);
    n_assert++;
    if (timeout || act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_count: got %0d words (timeout %0d) want %0d", act_q.size(), timeout, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
      if (a !== e) begin n_fail++; $display("FAIL midreset_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_err();
    word_t e, a;
    msg_q.delete(); msg_q.push_back($urandom); msg_nb = 5;
    push_expected();
    run_message(0);
    n_assert++;
    if (timeout || act_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL err_count: got %0d words (timeout %0d) want %0d", act_q.size(), timeout, exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_assert++;
      if (a !== e) begin n_fail++; $display("FAIL err_word: got %h/%0d/%b want %h/%0d/%b", a.data, a.idx, a.last, e.data, e.idx, e.last); end
    end
    exp_q.delete(); act_q.delete();
    n_assert++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got err %b want 1", err); end
    msg_q.delete(); msg_q.push_back(32'h6162_6300); msg_nb = 3;
    run_message(0);
    act_q.delete();
    n_assert++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got err %b want 1", err); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got err %b want 0", err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_nbytes = 3'd0; bus.out_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_55();
    test_56();
    test_stall();
    test_reset_mid();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
